// File: rtl/regfile_issue_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_issue_pkg
// Brief  : Shared widths, opcodes and helpers for the regfile issue unit.
// Rev    : 1.0  initial release
// ============================================================================
package regfile_issue_pkg;

    localparam int DATA_W  = 12;
    localparam int ADDR_W  = 3;
    localparam int OP_W    = 3;
    localparam int SHAMT_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_SHL = 3'd5;
    localparam logic [OP_W-1:0] OP_SHR = 3'd6;
    localparam logic [OP_W-1:0] OP_LDI = 3'd7;

    // Shift amounts at or above this value push every bit out of the word.
    localparam logic [SHAMT_W-1:0] SHIFT_SAT = SHAMT_W'(DATA_W);

    typedef logic [OP_W-1:0]   op_t;
    typedef logic [ADDR_W-1:0] regAddr_t;
    typedef logic [DATA_W-1:0] regData_t;

    function automatic logic usesSources(input op_t op);
        return op != OP_LDI;
    endfunction

endpackage : regfile_issue_pkg
`default_nettype wire

// File: rtl/regfile_issue_unit_if.sv
`default_nettype none
// ============================================================================
// Module : regfile_issue_unit_if
// Brief  : Request, register-file and result bundle of the issue unit.
// Rev    : 1.0  initial release
// ============================================================================
interface regfile_issue_unit_if
    import regfile_issue_pkg::*;
;
    logic     in_valid;
    logic     in_ready;
    op_t      in_op;
    regAddr_t in_rd;
    regAddr_t in_rs1;
    regAddr_t in_rs2;
    regData_t in_imm;

    regAddr_t rf_read1_addr;
    regAddr_t rf_read2_addr;
    regData_t rf_read_data1;
    regData_t rf_read_data2;
    logic     rf_we;
    regAddr_t rf_write_addr;
    regData_t rf_write_data;

    logic     result_valid;
    regData_t result_data;
    logic     busy;

    // Issue unit side.
    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        input  rf_read_data1, rf_read_data2,
        output in_ready, rf_read1_addr, rf_read2_addr,
        output rf_we, rf_write_addr, rf_write_data,
        output result_valid, result_data, busy
    );

    // Decode / register file side.
    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        output rf_read_data1, rf_read_data2,
        input  in_ready, rf_read1_addr, rf_read2_addr,
        input  rf_we, rf_write_addr, rf_write_data,
        input  result_valid, result_data, busy
    );

endinterface : regfile_issue_unit_if
`default_nettype wire

// File: rtl/regfile_issue_unit_alu12.sv
`default_nettype none
// ============================================================================
// Module : alu12
// Brief  : Combinational 12-bit ALU used by the EX stage.
// Rev    : 1.0  initial release
// ============================================================================
module alu12
    import regfile_issue_pkg::*;
(
    input  wire op_t      i_op,
    input  wire regData_t i_a,
    input  wire regData_t i_b,
    input  wire regData_t i_imm,
    output regData_t      o_result
);

    logic [SHAMT_W-1:0] w_shamt;
    logic               w_shiftSat;

    assign w_shamt    = i_b[SHAMT_W-1:0];
    assign w_shiftSat = (w_shamt >= SHIFT_SAT);

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SHL:  o_result = w_shiftSat ? '0 : (i_a << w_shamt);
            OP_SHR:  o_result = w_shiftSat ? '0 : (i_a >> w_shamt);
            OP_LDI:  o_result = i_imm;
            default: o_result = '0;
        endcase
    end

endmodule : alu12
`default_nettype wire

// File: rtl/regfile_issue_unit.sv
`default_nettype none
// ============================================================================
// Module : regfile_issue_unit
// Brief  : ID/EX/WB execute pipeline driving a 2R1W register file.
//          Define ALU_FWD_EN for EX/WB operand forwarding (never stalls);
//          otherwise dependent requests stall until the write has landed.
// Rev    : 1.0  initial release
// ============================================================================
module regfile_issue_unit
    import regfile_issue_pkg::*;
(
    input  wire           clk,
    input  wire           rst_n,
    regfile_issue_unit_if.slave bus
);

    logic     w_ready;
    logic     w_accept;
    regData_t w_opA;
    regData_t w_opB;
    regData_t w_aluResult;

    logic     r_exValid;
    op_t      r_exOp;
    regAddr_t r_exRd;
    regData_t r_exA;
    regData_t r_exB;
    regData_t r_exImm;

    logic     r_wbValid;
    regAddr_t r_wbRd;
    regData_t r_wbData;

    assign bus.rf_read1_addr = bus.in_rs1;
    assign bus.rf_read2_addr = bus.in_rs2;

`ifdef ALU_FWD_EN
    // The younger EX result overrides WB; WB covers the register file
    // still returning the old value during its write cycle.
    always_comb begin
        w_opA = bus.rf_read_data1;
        if (r_wbValid && (r_wbRd == bus.in_rs1)) w_opA = r_wbData;
        if (r_exValid && (r_exRd == bus.in_rs1)) w_opA = w_aluResult;
        w_opB = bus.rf_read_data2;
        if (r_wbValid && (r_wbRd == bus.in_rs2)) w_opB = r_wbData;
        if (r_exValid && (r_exRd == bus.in_rs2)) w_opB = w_aluResult;
    end

    assign w_ready = 1'b1;
`else
    logic w_hazard;

    assign w_opA = bus.rf_read_data1;
    assign w_opB = bus.rf_read_data2;

    always_comb begin
        w_hazard = 1'b0;
        if (usesSources(bus.in_op)) begin
            if (r_exValid && ((r_exRd == bus.in_rs1) || (r_exRd == bus.in_rs2))) w_hazard = 1'b1;
            if (r_wbValid && ((r_wbRd == bus.in_rs1) || (r_wbRd == bus.in_rs2))) w_hazard = 1'b1;
        end
    end

    assign w_ready = !w_hazard;
`endif

    assign bus.in_ready = w_ready;
    assign w_accept     = bus.in_valid && w_ready;

    alu12 u_alu (
        .i_op     (r_exOp),
        .i_a      (r_exA),
        .i_b      (r_exB),
        .i_imm    (r_exImm),
        .o_result (w_aluResult)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exValid <= 1'b0;
            r_exOp    <= OP_ADD;
            r_exRd    <= '0;
            r_exA     <= '0;
            r_exB     <= '0;
            r_exImm   <= '0;
            r_wbValid <= 1'b0;
            r_wbRd    <= '0;
            r_wbData  <= '0;
        end else begin
            r_exValid <= w_accept;
            if (w_accept) begin
                r_exOp  <= bus.in_op;
                r_exRd  <= bus.in_rd;
                r_exA   <= w_opA;
                r_exB   <= w_opB;
                r_exImm <= bus.in_imm;
            end
            r_wbValid <= r_exValid;
            if (r_exValid) begin
                r_wbRd   <= r_exRd;
                r_wbData <= w_aluResult;
            end
        end
    end

    assign bus.rf_we         = r_wbValid;
    assign bus.rf_write_addr = r_wbRd;
    assign bus.rf_write_data = r_wbData;
    assign bus.result_valid  = r_wbValid;
    assign bus.result_data   = r_wbData;
    assign bus.busy          = r_exValid || r_wbValid;

endmodule : regfile_issue_unit
`default_nettype wire

// File: tb/tb_regfile_issue_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_issue_unit
// Brief  : Directed plus random bench; sequential-ISA reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_regfile_issue_unit;

`ifdef ALU_FWD_EN
    localparam int c_depStall = 0;
`else
    localparam int c_depStall = 2;
`endif

    typedef struct packed {
        int          due;
        logic [2:0]  addr;
        logic [11:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rfClear = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [11:0] rfMem      [8];
    logic [11:0] archRegs   [8];
    logic [11:0] commitRegs [8];
    wr_t         expQ[$];

    regfile_issue_unit_if bus();

    regfile_issue_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file: combinational reads, write on the edge after rf_we.
    assign bus.rf_read_data1 = rfMem[bus.rf_read1_addr];
    assign bus.rf_read_data2 = rfMem[bus.rf_read2_addr];
    always @(posedge clk) begin
        if (rfClear) begin
            for (int i = 0; i < 8; i++) rfMem[i] <= '0;
        end else if (bus.rf_we) begin
            rfMem[bus.rf_write_addr] <= bus.rf_write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] refAlu(input int op, input int a, input int b, input int imm);
        int r;
        int sh;
        sh = b % 16;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (sh >= 12) ? 0 : a * (2 ** sh);
            6: r = (sh >= 12) ? 0 : a / (2 ** sh);
            default: r = imm;
        endcase
        return r[11:0];
    endfunction

    // Without forwarding a source op waits while any in-flight op targets its sources.
    function automatic logic refReady();
`ifdef ALU_FWD_EN
        return 1'b1;
`else
        if (bus.in_op == 3'd7) return 1'b1;
        foreach (expQ[i])
            if (expQ[i].addr == bus.in_rs1 || expQ[i].addr == bus.in_rs2) return 1'b0;
        return 1'b1;
`endif
    endfunction

    task automatic cycleStep(output bit accepted);
        logic        expReady;
        logic        expWe;
        logic [11:0] res;
        expReady = refReady();
        expWe    = (expQ.size() > 0) && (expQ[0].due == cyc);
        chk("in_ready", bus.in_ready, expReady);
        chk("busy", bus.busy, expQ.size() > 0);
        chk("rf_we", bus.rf_we, expWe);
        chk("result_valid", bus.result_valid, expWe);
        if (expWe) begin
            chk("wr_addr", bus.rf_write_addr, expQ[0].addr);
            chk("wr_data", bus.rf_write_data, expQ[0].data);
            chk("result_data", bus.result_data, expQ[0].data);
            commitRegs[expQ[0].addr] = expQ[0].data;
            void'(expQ.pop_front());
        end
        accepted = bus.in_valid && expReady;
        if (accepted) begin
            res = refAlu(bus.in_op, archRegs[bus.in_rs1], archRegs[bus.in_rs2], bus.in_imm);
            expQ.push_back('{due: cyc + 2, addr: bus.in_rd, data: res});
            archRegs[bus.in_rd] = res;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [11:0] imm, output int stalls);
        bit acc;
        acc = 1'b0;
        stalls = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_imm   = imm;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            cycleStep(acc);
            @(posedge clk);
            #1;
            if (acc) break;
            stalls++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            cycleStep(acc);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset(input int n);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        expQ.delete();
        archRegs = commitRegs;
        repeat (n) begin
            @(negedge clk);
            chk("rst_rf_we", bus.rf_we, 1'b0);
            chk("rst_result_valid", bus.result_valid, 1'b0);
            chk("rst_busy", bus.busy, 1'b0);
            chk("rst_wr_addr", bus.rf_write_addr, 3'd0);
            chk("rst_wr_data", bus.rf_write_data, 12'd0);
            chk("rst_result_data", bus.result_data, 12'd0);
            chk("rst_in_ready", bus.in_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          s;
        logic [2:0]  rOp, rRd, rS1, rS2;
        logic [11:0] rImm;

        for (int i = 0; i < 8; i++) begin
            archRegs[i]   = '0;
            commitRegs[i] = '0;
        end
        bus.in_valid = 1'b0;
        bus.in_op    = 3'd7;
        bus.in_rd    = '0;
        bus.in_rs1   = '0;
        bus.in_rs2   = '0;
        bus.in_imm   = '0;

        @(posedge clk);
        #1;
        doReset(3);
        rfClear = 1'b0;

        // Back-to-back LDI, LDI, dependent ADD.
        issue(3'd7, 3'd1, 3'd0, 3'd0, 12'h005, s);
        chk("ldi1_stall", s, 0);
        issue(3'd7, 3'd2, 3'd0, 3'd0, 12'h003, s);
        chk("ldi2_stall", s, 0);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 12'h000, s);
        chk("add_dep_stall", s, c_depStall);
        idle(3);
        chk("r1", rfMem[1], 12'h005);
        chk("r2", rfMem[2], 12'h003);
        chk("r3", rfMem[3], 12'h008);

        issue(3'd1, 3'd4, 3'd2, 3'd1, 12'h000, s);
        idle(3);
        chk("sub_wrap", rfMem[4], 12'hFFE);

        issue(3'd7, 3'd1, 3'd0, 3'd0, 12'h001, s);
        issue(3'd7, 3'd2, 3'd0, 3'd0, 12'd12, s);
        issue(3'd5, 3'd5, 3'd1, 3'd2, 12'h000, s);
        idle(3);
        chk("shl12", rfMem[5], 12'h000);
        issue(3'd7, 3'd2, 3'd0, 3'd0, 12'd11, s);
        issue(3'd5, 3'd5, 3'd1, 3'd2, 12'h000, s);
        idle(3);
        chk("shl11", rfMem[5], 12'h800);

        issue(3'd7, 3'd1, 3'd0, 3'd0, 12'h007, s);
        issue(3'd0, 3'd2, 3'd1, 3'd1, 12'h000, s);
        chk("ldi_add_stall", s, c_depStall);
        idle(3);
        chk("r2_double", rfMem[2], 12'h00E);

        issue(3'd7, 3'd1, 3'd0, 3'd0, 12'h006, s);
        idle(3);
        issue(3'd0, 3'd1, 3'd1, 3'd1, 12'h000, s);
        chk("self_dep_stall", s, 0);
        issue(3'd3, 3'd2, 3'd1, 3'd1, 12'h000, s);
        chk("or_dep_stall", s, c_depStall);
        idle(3);
        chk("r1_self", rfMem[1], 12'h00C);
        chk("r2_mov", rfMem[2], 12'h00C);

        // Reset while the op sits in EX: its write must never appear.
        issue(3'd7, 3'd6, 3'd0, 3'd0, 12'h123, s);
        doReset(3);
        idle(2);
        chk("r6_discarded", rfMem[6], 12'h000);
        issue(3'd7, 3'd6, 3'd0, 3'd0, 12'h456, s);
        idle(3);
        chk("r6_after_rst", rfMem[6], 12'h456);

        for (int i = 0; i < 300; i++) begin
            rOp  = 3'($urandom_range(0, 7));
            rRd  = 3'($urandom_range(0, 7));
            rS1  = 3'($urandom_range(0, 7));
            rS2  = 3'($urandom_range(0, 7));
            rImm = 12'($urandom);
            issue(rOp, rRd, rS1, rS2, rImm, s);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if (i == 150) doReset(2);
        end
        idle(4);
        for (int i = 0; i < 8; i++) chk("final_reg", rfMem[i], commitRegs[i]);
        chk("queue_drained", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_issue_unit
`default_nettype wire

// File: doc/regfile_issue_unit.md
# regfile_issue_unit

Three-stage execute pipeline that drives the 8 x 12-bit, two-read/one-write register file as its initiator. Accepts one ALU operation per cycle over a valid/ready handshake, issues both register reads, executes a 12-bit ALU op and writes the result back through the register file's write port. Sits between instruction decode and the register file in the lab datapath.

## Interface
- DATA_W, 12, operand/result width
- ADDR_W, 3, register address width (2**ADDR_W registers)
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  unit accepts request this cycle
- in_op  in  3  opcode (see Operation)
- in_rd, in_rs1, in_rs2  in  ADDR_W  destination / source registers
- in_imm  in  DATA_W  immediate, used only by LDI
- rf_read1_addr, rf_read2_addr  out  ADDR_W  to register file read ports
- rf_read_data1, rf_read_data2  in  DATA_W  combinational read data from register file
- rf_we  out  1  register file write enable
- rf_write_addr  out  ADDR_W  write address
- rf_write_data  out  DATA_W  write data
- result_valid  out  1  one-cycle pulse, coincident with rf_we
- result_data  out  DATA_W  copy of rf_write_data
- busy  out  1  any pipeline stage valid

## Operation
- Opcodes: 0 ADD, 1 SUB (rs1-rs2), 2 AND, 3 OR, 4 XOR, 5 SHL (rs1 << rs2[3:0]), 6 SHR logical, 7 LDI (rd <- in_imm).
- All arithmetic mod 2**DATA_W; no carry/overflow output. Shift amount >= DATA_W yields 0.
- Stage ID (combinational): rf_read1_addr = in_rs1, rf_read2_addr = in_rs2; on accept (in_valid & in_ready) operands, op, rd, imm latched into EX register.
- Stage EX: ALU result computed combinationally, latched with rd into WB register.
- Stage WB: rf_we = wb_valid, rf_write_addr = wb_rd, rf_write_data = wb_data; register file writes on the following edge.
- Operand selection at accept, per source, priority order: EX stage result if ex_valid & ex_op != none & ex_rd == rs; else WB data if wb_valid & wb_rd == rs; else rf_read_data. WB forwarding is required because the register file returns the old value during the write cycle.
- LDI ignores rs1/rs2 and never causes a hazard.
- in_ready = 1 when forwarding is compiled in (pipeline never stalls).

## Timing
- Accept at edge N -> EX valid in cycle N..N+1 -> rf_we/result_valid high for cycle after edge N+1 -> register updated at edge N+2. Throughput 1 op/cycle.
- rd == rs in the same op: reads pre-write value.
- Reset (any time, including mid-pipeline): all valid bits 0; rf_we, result_valid, busy = 0; rf_write_addr, rf_write_data, result_data = 0; in-flight ops discarded, no write occurs. in_ready = 1 after reset.
- in_ready is combinational from in_rs1/in_rs2/in_op and pipeline state; requester must hold request while in_valid & !in_ready.

## Configuration
- ALU_FWD_EN defined: forwarding paths as above; in_ready tied 1.
- ALU_FWD_EN undefined: no forwarding muxes; in_ready = 0 while a non-LDI request's rs1 or rs2 matches rd of a valid EX or WB entry; operands always from register file. Dependent back-to-back op stalls 2 cycles.

## Structure
- Package regfile_issue_pkg: DATA_W, ADDR_W defaults, opcode constants (OP_ADD..OP_LDI), shift-saturation constant.
- Sub-module alu12: purely combinational op/a/b/imm -> result; instantiated once in EX.

## Test plan
- LDI r1=5, LDI r2=3, ADD r3=r1,r2 on consecutive cycles (FWD_EN) -> in_ready stays 1; writes r1=0x005, r2=0x003, r3=0x008 on three consecutive rf_we cycles.
- SUB r4=r2,r1 with r1=5, r2=3 -> rf_write_data = 0xFFE, addr 4.
- SHL r5=r1,r2 with r1=1, r2=12 -> 0x000; with r2=11 -> 0x800.
- Without ALU_FWD_EN: LDI r1=7 then ADD r2=r1,r1 -> in_ready low exactly 2 cycles, then r2 = 0x00E.
- ADD r1=r1,r1 with r1=6 -> write 0x00C using old value; readback via subsequent MOV-equivalent OR r2=r1,r1 -> 0x00C.
- Assert rst_n low while an op sits in EX -> rf_we never pulses for it; all outputs 0 during reset; first op after release completes normally.
